sphere3_norm_check: RTL and testbench

SPHERE3_NORM_CHECK -- requirements
Module: sphere3_norm_check

---
 rtl/sphere3_norm_check.sv | 156 +++++++++++++++
 tb/tb_sphere3_norm_check.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sphere3_norm_check.sv
// sphere3_norm_check: checks that a 4-component Q16.16 point from the sphere3
// generator lies on the unit 3-sphere. It accumulates x^2+y^2+z^2+w^2 over four
// MAC cycles, then compares the result against 1.0 with a caller-supplied
// tolerance. Running counts of checked and failed points are kept as well.
module sphere3_norm_check #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic [31:0]      in_z,
    input  logic [31:0]      in_w,
    input  logic [31:0]      tol,
    input  logic             clr_cnt,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      norm_sq,
    output logic             pass,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    typedef enum logic [1:0] {IDLE, MAC, CMP} state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q;
    logic [31:0]        x_q, y_q, z_q, w_q, tol_q;
    logic [65:0]        acc_q;
    logic [31:0]        norm_q;
    logic               pass_q;
    logic               ov_q;
    logic [CNT_W-1:0]   chk_q, fail_q;

    logic signed [31:0] comp_sel;
    logic signed [63:0] comp_ext;
    logic signed [63:0] sq_s;
    logic [63:0]        sq_u;
    logic [31:0]        norm_new;
    logic               pass_new;

    // Drop the 16 fractional LSBs (truncation toward zero) and saturate when
    // the integer part does not fit in 16 bits.
    function automatic logic [31:0] sat_norm(input logic [65:0] acc);
        if (acc[65:48] != 18'd0) return 32'hFFFF_FFFF;
        return acc[47:16];
    endfunction

    // |n - 1.0| evaluated in 33 bits so neither direction of the subtraction wraps.
    function automatic logic tol_ok(input logic [31:0] n, input logic [31:0] t);
        logic [32:0] n33;
        logic [32:0] one33;
        logic [32:0] diff;
        n33   = {1'b0, n};
        one33 = 33'h0_0001_0000;
        diff  = (n33 >= one33) ? (n33 - one33) : (one33 - n33);
        return diff <= {1'b0, t};
    endfunction

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + CNT_W'(1);
    endfunction

    // Select the component for this MAC step and square it; a square is never negative.
    always_comb begin
        comp_sel = 32'sd0;
        case (idx_q)
            2'd0: comp_sel = $signed(x_q);
            2'd1: comp_sel = $signed(y_q);
            2'd2: comp_sel = $signed(z_q);
            2'd3: comp_sel = $signed(w_q);
            default: comp_sel = 32'sd0;
        endcase
        comp_ext = {{32{comp_sel[31]}}, comp_sel};
        sq_s     = comp_ext * comp_ext;
        sq_u     = sq_s;
        norm_new = sat_norm(acc_q);
        pass_new = tol_ok(norm_new, tol_q);
    end

    // Next-state logic: accept in IDLE, four MAC steps, one compare step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = MAC;
            MAC:     if (idx_q == 2'd3) state_d = CMP;
            CMP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the point and tolerance on the accepting edge only.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && in_valid) begin
            x_q   <= in_x;
            y_q   <= in_y;
            z_q   <= in_z;
            w_q   <= in_w;
            tol_q <= tol;
        end
    end

    // State, accumulator, result and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            acc_q   <= '0;
            norm_q  <= 32'd0;
            pass_q  <= 1'b0;
            ov_q    <= 1'b0;
            chk_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            ov_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q <= '0;
                        idx_q <= 2'd0;
                    end
                end
                MAC: begin
                    acc_q <= acc_q + {2'b00, sq_u};
                    idx_q <= idx_q + 2'd1;
                end
                CMP: begin
                    norm_q <= norm_new;
                    pass_q <= pass_new;
                    ov_q   <= 1'b1;
                end
                default: ;
            endcase
            // A clear request overrides a coinciding count update.
            if (clr_cnt) begin
                chk_q  <= '0;
                fail_q <= '0;
            end else if (state_q == CMP) begin
                chk_q <= sat_inc(chk_q);
                if (!pass_new) fail_q <= sat_inc(fail_q);
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = ov_q;
    assign norm_sq   = norm_q;
    assign pass      = pass_q;
    assign check_cnt = chk_q;
    assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_sphere3_norm_check.sv
// Bench for sphere3_norm_check: directed corner points, a continuous stream,
// clear/reset interactions and randomized points against an arithmetic model.
module tb_sphere3_norm_check;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [31:0]      in_x, in_y, in_z, in_w, tol;
    logic             clr_cnt;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      norm_sq;
    logic             pass;
    logic [CNT_W-1:0] check_cnt, fail_cnt;

    int total = 0;
    int bad   = 0;
    int m_chk = 0;
    int m_fail = 0;

    sphere3_norm_check #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_z      (in_z),
        .in_w      (in_w),
        .tol       (tol),
        .clr_cnt   (clr_cnt),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .norm_sq   (norm_sq),
        .pass      (pass),
        .check_cnt (check_cnt),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact sum of squares, integer part saturated, then distance from 1.0.
    task automatic model(input logic [31:0] x, y, z, w, t,
                         output logic [31:0] n, output logic p);
        logic [65:0] s;
        longint      v;
        longint      d;
        logic [31:0] c[4];
        c[0] = x; c[1] = y; c[2] = z; c[3] = w;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            v = longint'($signed(c[i]));
            s = s + {2'b00, 64'(v * v)};
        end
        if (s >= (66'd1 << 48)) n = 32'hFFFF_FFFF;
        else                    n = s[47:16];
        d = longint'({32'd0, n}) - 64'sd65536;
        if (d < 0) d = -d;
        p = (d <= longint'({32'd0, t}));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"}, in_ready, 1);
        chk({tag, "_ovalid"}, out_valid, 0);
        chk({tag, "_norm"}, norm_sq, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_chk"}, check_cnt, 0);
        chk({tag, "_fail"}, fail_cnt, 0);
    endtask

    // Offer one point, hammer the inputs with junk while busy, then check the result.
    task automatic do_point(input string tag, input logic [31:0] x, y, z, w, t,
                            input bit clr_on_cmp);
        logic [31:0] en;
        logic        ep;
        int          k;
        k = 0;
        while (!in_ready && k < 10) begin
            tick();
            k++;
        end
        chk({tag, "_ready_wait"}, in_ready, 1);
        model(x, y, z, w, t, en, ep);
        in_x = x; in_y = y; in_z = z; in_w = w; tol = t;
        in_valid = 1'b1;
        tick();
        for (int c = 1; c <= 5; c++) begin
            chk({tag, "_busy_ready"}, in_ready, 0);
            chk({tag, "_busy_ovalid"}, out_valid, 0);
            in_valid = 1'b1;
            in_x = $urandom; in_y = $urandom; in_z = $urandom; in_w = $urandom;
            tol  = $urandom;
            if (c == 5 && clr_on_cmp) clr_cnt = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        if (clr_on_cmp) begin
            m_chk = 0;
            m_fail = 0;
        end else begin
            if (m_chk < CMAX) m_chk++;
            if (!ep && m_fail < CMAX) m_fail++;
        end
        chk({tag, "_ovalid"}, out_valid, 1);
        chk({tag, "_ready_done"}, in_ready, 1);
        chk({tag, "_norm"}, norm_sq, en);
        chk({tag, "_pass"}, pass, ep);
        chk({tag, "_chk"}, check_cnt, m_chk);
        chk({tag, "_fail"}, fail_cnt, m_fail);
        tick();
        chk({tag, "_ovalid_drop"}, out_valid, 0);
        chk({tag, "_norm_hold"}, norm_sq, en);
        chk({tag, "_pass_hold"}, pass, ep);
    endtask

    initial begin
        int          pulses;
        int          last;
        int          e;
        logic [31:0] r[4];
        logic [31:0] rt;
        bit          rc;

        rst_n = 1'b0; in_valid = 1'b1; clr_cnt = 1'b0;
        in_x = 32'h0001_0000; in_y = 0; in_z = 0; in_w = 0; tol = 0;
        tick(); tick(); tick();
        check_reset_state("reset");
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle_stay_ready", in_ready, 1);
        chk("idle_stay_ovalid", out_valid, 0);

        // Directed corner points
        do_point("unit_x", 32'h0001_0000, 0, 0, 0, 0, 0);
        do_point("halves", 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 0, 0);
        do_point("halves_negw", 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'hFFFF_8000, 0, 0);
        do_point("zero", 0, 0, 0, 0, 32'h0000_1000, 0);
        do_point("max_neg_x", 32'h8000_0000, 0, 0, 0, 32'hFFFF_FFFF, 0);
        do_point("tol_edge_in", 32'h0001_0000, 32'h0000_0100, 0, 0, 32'h0000_0001, 0);
        do_point("tol_edge_out", 32'h0001_0000, 32'h0000_0200, 0, 0, 32'h0000_0003, 0);
        do_point("trunc", 32'h0000_0001, 32'h0000_00FF, 0, 0, 0, 0);
        do_point("clr_on_cmp", 32'h0001_0000, 0, 0, 0, 0, 1);

        // Continuous in_valid: one acceptance per busy window, counters saturate
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        m_chk = 0; m_fail = 0;
        chk("clr_idle_chk", check_cnt, 0);
        chk("clr_idle_fail", fail_cnt, 0);
        in_x = 32'h0001_0000; in_y = 0; in_z = 0; in_w = 0; tol = 0;
        in_valid = 1'b1;
        pulses = 0; last = -1; e = 0;
        while (pulses < 20 && e < 300) begin
            tick();
            e++;
            if (out_valid) begin
                if (last >= 0) chk("stream_spacing", e - last, 6);
                last = e;
                pulses++;
            end
            if (pulses > 0) chk("stream_ready", in_ready, out_valid);
        end
        in_valid = 1'b0;
        chk("stream_pulses", pulses, 20);
        chk("stream_chk_sat", check_cnt, CMAX);
        chk("stream_fail", fail_cnt, 0);
        m_chk = CMAX; m_fail = 0;

        // Reset while a point is in the MAC phase
        in_x = 32'h0001_0000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        check_reset_state("mid_mac_reset");
        rst_n = 1'b1;
        m_chk = 0; m_fail = 0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        chk("mid_mac_no_pulse", pulses, 0);
        chk("mid_mac_norm", norm_sq, 0);

        // Randomized points, mixing near-unit and arbitrary components
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (n % 2 == 0) r[i] = 32'($urandom_range(0, 32'h0001_0000)) - 32'h0000_8000;
                else            r[i] = $urandom;
            end
            rt = (n % 3 == 0) ? $urandom : 32'($urandom_range(0, 32'h0000_4000));
            rc = ($urandom_range(0, 5) == 0);
            do_point("rand", r[0], r[1], r[2], r[3], rt, rc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
